// File: rtl/tx_stretch_pkg.sv
// Shared types and defaults for the TX valid-stretching buffer.
package tx_stretch_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH      = 4;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 4;
  localparam int unsigned PTR_WIDTH          = $clog2(DEFAULT_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StWaitRise,
    StWaitFall
  } state_e;

endpackage

// File: rtl/tx_stretch_buffer_sync_fifo.sv
// Power-of-two synchronous FIFO with registered full/empty flags.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  do_push, do_pop;

  // Flags come from the registered count, so a same-cycle pop never frees room for a push.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
    full_d  = (count_d == CntW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/tx_stretch_buffer.sv
// Buffers TX bytes and presents each with valid stretched for HOLD_CNT+1 cycles,
// then waits for the TX busy handshake (or a timeout) before the next byte.
module tx_stretch_buffer
  import tx_stretch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VLD,
  input  logic [CNT_WIDTH-1:0]  HOLD_CNT,
  input  logic                  BUSY,
  input  logic                  CLR_OVF,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VLD,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  OVF
);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_vld_q, out_vld_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  fifo_full, fifo_empty, pop;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (IN_VLD),
    .wdata_i (IN_DATA),
    .pop_i   (pop),
    .rdata_o (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !BUSY) begin
          pop        = 1'b1;
          out_data_d = head_data;
          out_vld_d  = 1'b1;
          cnt_d      = '0;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (cnt_q == HOLD_CNT) begin
          out_vld_d  = 1'b0;
          out_data_d = '0;
          cnt_d      = '0;
          state_d    = StWaitRise;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StWaitRise: begin
        // No busy seen within the window: transfer missed or already done.
        if (BUSY) begin
          state_d = StWaitFall;
        end else if (cnt_q == HOLD_CNT) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StWaitFall: begin
        if (!BUSY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (IN_VLD && fifo_full) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign OUT_DATA = out_data_q;
  assign OUT_VLD  = out_vld_q;
  assign FULL     = fifo_full;
  assign EMPTY    = fifo_empty;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_tx_stretch_buffer.sv
// Directed scenarios plus randomized traffic against a queue-based behavioural model.
module tb_tx_stretch_buffer;

  localparam int unsigned Depth = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] IN_DATA = '0;
  logic       IN_VLD = 1'b0;
  logic [3:0] HOLD_CNT = '0;
  logic       BUSY = 1'b0;
  logic       CLR_OVF = 1'b0;
  logic [7:0] OUT_DATA;
  logic       OUT_VLD, FULL, EMPTY, OVF;

  tx_stretch_buffer #(
    .DATA_WIDTH (8),
    .DEPTH      (Depth),
    .CNT_WIDTH  (4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_DATA  (IN_DATA),
    .IN_VLD   (IN_VLD),
    .HOLD_CNT (HOLD_CNT),
    .BUSY     (BUSY),
    .CLR_OVF  (CLR_OVF),
    .OUT_DATA (OUT_DATA),
    .OUT_VLD  (OUT_VLD),
    .FULL     (FULL),
    .EMPTY    (EMPTY),
    .OVF      (OVF)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: mode 0 = ready, 1 = presenting, 2 = awaiting busy, 3 = awaiting busy release.
  logic [7:0] mq[$];
  logic [7:0] m_data = '0;
  logic       m_vld = 1'b0;
  logic       m_ovf = 1'b0;
  int         m_mode = 0;
  int         m_left = 0;
  int         m_pops = 0;
  bit         model_on = 1'b0;

  task automatic model_edge();
    bit was_full;
    bit was_empty;
    if (!RST) begin
      mq.delete();
      m_data = '0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_mode = 0;
      m_left = 0;
    end else begin
      was_full  = (mq.size() == Depth);
      was_empty = (mq.size() == 0);
      case (m_mode)
        0: if (!was_empty && !BUSY) begin
          m_data = mq.pop_front();
          m_vld  = 1'b1;
          m_left = HOLD_CNT;
          m_mode = 1;
          m_pops++;
        end
        1: if (m_left == 0) begin
          m_vld  = 1'b0;
          m_data = '0;
          m_left = HOLD_CNT;
          m_mode = 2;
        end else m_left--;
        2: if (BUSY) m_mode = 3;
           else if (m_left == 0) m_mode = 0;
           else m_left--;
        default: if (!BUSY) m_mode = 0;
      endcase
      if (IN_VLD && was_full) m_ovf = 1'b1;
      else if (CLR_OVF) m_ovf = 1'b0;
      if (IN_VLD && !was_full) mq.push_back(IN_DATA);
    end
  endtask

  always @(posedge CLK) model_edge();

  always @(negedge CLK) begin
    if (model_on) begin
      check("out_vld", OUT_VLD, m_vld);
      check("out_data", OUT_DATA, m_data);
      check("full", FULL, mq.size() == Depth);
      check("empty", EMPTY, mq.size() == 0);
      check("ovf", OVF, m_ovf);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0] got_q[$];
  int hi, rise2, n_pulse, len, gap, first_len, first_gap, pops0, rises, maxlen;
  logic prev;

  initial begin
    // Reset
    RST = 1'b0;
    tick();
    model_on = 1'b1;
    tick();
    check("rst_out_vld", OUT_VLD, 0);
    check("rst_empty", EMPTY, 1);
    check("rst_full", FULL, 0);
    check("rst_ovf", OVF, 0);
    RST = 1'b1;

    // Single byte with busy handshake
    HOLD_CNT = 4'd15;
    IN_DATA  = 8'hA5;
    IN_VLD   = 1'b1;
    tick();
    check("s1_empty_low", EMPTY, 0);
    check("s1_vld_not_yet", OUT_VLD, 0);
    IN_VLD = 1'b0;
    tick();
    check("s1_vld_rise", OUT_VLD, 1);
    check("s1_data", OUT_DATA, 8'hA5);
    hi = 1;
    rise2 = -1;
    for (int c = 1; c < 90; c++) begin
      BUSY    = (c >= 20 && c < 60);
      IN_VLD  = (c == 30);
      IN_DATA = 8'h5A;
      tick();
      if (c == 30) check("s1_data_zero", OUT_DATA, 0);
      if (c < 40 && OUT_VLD) hi++;
      if (c >= 40 && OUT_VLD && rise2 < 0) rise2 = c;
    end
    IN_VLD = 1'b0;
    BUSY   = 1'b0;
    check("s1_hold_len", hi, 16);
    check("s1_next_pop_cycle", rise2, 61);
    repeat (30) tick();

    // Burst into full FIFO, overflow, then timeout-paced drain
    HOLD_CNT = 4'd3;
    BUSY = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      IN_DATA = 8'(8'h11 * (i + 1));
      IN_VLD  = 1'b1;
      tick();
      if (i == 3) check("s2_full_after_4", FULL, 1);
    end
    IN_VLD = 1'b0;
    check("s2_ovf_set", OVF, 1);
    BUSY = 1'b0;
    prev = OUT_VLD;
    n_pulse = 0; len = 0; gap = 0; first_len = -1; first_gap = -1;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (OUT_VLD && !prev) begin
        got_q.push_back(OUT_DATA);
        if (n_pulse == 1) first_gap = gap;
        n_pulse++;
        len = 0;
      end
      if (!OUT_VLD && prev) begin
        if (first_len < 0) first_len = len;
        gap = 0;
      end
      if (OUT_VLD) len++;
      else gap++;
      prev = OUT_VLD;
    end
    check("s2_byte_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check("s2_order", got_q[i], 8'(8'h11 * (i + 1)));
    check("s2_high_len", first_len, 4);
    check("s2_low_gap", first_gap, 5);
    check("s2_empty_end", EMPTY, 1);
    check("s2_ovf_sticky", OVF, 1);
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    check("s2_ovf_cleared", OVF, 0);

    // Reset on the third valid cycle discards everything
    HOLD_CNT = 4'd15;
    IN_DATA = 8'h3C;
    IN_VLD = 1'b1;
    tick();
    IN_DATA = 8'h4D;
    tick();
    IN_VLD = 1'b0;
    tick();
    tick();
    check("s3_vld_before_rst", OUT_VLD, 1);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    check("s3_vld_after_rst", OUT_VLD, 0);
    check("s3_empty_after_rst", EMPTY, 1);
    check("s3_data_after_rst", OUT_DATA, 0);
    IN_DATA = 8'h77;
    IN_VLD = 1'b1;
    tick();
    IN_VLD = 1'b0;
    check("s3_vld_latency", OUT_VLD, 0);
    tick();
    check("s3_vld_rise", OUT_VLD, 1);
    check("s3_data", OUT_DATA, 8'h77);
    repeat (40) tick();

    // Random traffic, HOLD_CNT=0 first, then random HOLD_CNT while the model is ready
    HOLD_CNT = 4'd0;
    for (int ph = 0; ph < 2; ph++) begin
      pops0 = m_pops;
      rises = 0; maxlen = 0; len = 0;
      prev = OUT_VLD;
      for (int c = 0; c < 400; c++) begin
        IN_VLD  = ($urandom_range(0, 2) == 0);
        IN_DATA = 8'($urandom);
        CLR_OVF = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 5) == 0) BUSY = ~BUSY;
        if (ph == 1 && m_mode == 0 && $urandom_range(0, 7) == 0) HOLD_CNT = 4'($urandom);
        tick();
        if (OUT_VLD && !prev) begin
          rises++;
          len = 0;
        end
        if (OUT_VLD) begin
          len++;
          if (len > maxlen) maxlen = len;
        end
        prev = OUT_VLD;
      end
      IN_VLD = 1'b0;
      CLR_OVF = 1'b0;
      check("rnd_pop_count", rises, m_pops - pops0);
      if (ph == 0) begin
        check("rnd_min_bytes", rises >= 10, 1);
        check("rnd_hold0_pulse", maxlen, 1);
      end
    end
    BUSY = 1'b0;
    repeat (80) tick();
    check("end_empty", EMPTY, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_stretch_buffer.md
# tx_stretch_buffer

Parametrised successor to the inline TX data/valid stretcher in the system top, running on REF_CLK between SYST_CTRL (TX_P_DATA/TX_DATA_VALID pulses) and the TX Data_Sync into the divided UART TX clock domain. It buffers up to DEPTH bytes and presents each byte with valid held for a runtime-programmable number of REF_CLK cycles, so a slow TX_CLK edge always samples it. It then waits for the synchronised TX_Busy handshake before presenting the next byte. Overflow is flagged instead of silently overwriting.

## Interface
- DATA_WIDTH, 8, byte width
- DEPTH, 4, FIFO entries; power of 2, at least 2
- CNT_WIDTH, 4, width of hold/timeout counter
- CLK  in  1  REF_CLK domain clock
- RST  in  1  synchronous, active-low reset
- IN_DATA  in  DATA_WIDTH  byte from SYST_CTRL
- IN_VLD  in  1  single-cycle write strobe
- HOLD_CNT  in  CNT_WIDTH  OUT_VLD high time = HOLD_CNT+1 cycles; quasi-static
- BUSY  in  1  TX_Busy already synchronised to CLK
- CLR_OVF  in  1  clears OVF
- OUT_DATA  out  DATA_WIDTH  byte to TX Data_Sync; 0 when OUT_VLD low
- OUT_VLD  out  1  stretched valid
- FULL  out  1  count == DEPTH
- EMPTY  out  1  count == 0
- OVF  out  1  sticky: a write was dropped

## Operation
- All outputs reset to 0, except EMPTY, which resets to 1. Reset also clears FIFO pointers, count, counter and state (IDLE). Reset mid-transfer drops OUT_VLD at the next edge and discards all buffered data.
- Push: IN_VLD && !FULL writes IN_DATA at wr_ptr; pointers wrap modulo DEPTH.
- Drop: IN_VLD && FULL drops the byte and sets OVF. FULL is evaluated on the registered count, so a pop in the same cycle does not rescue the byte.
- OVF: CLR_OVF clears it. If a new drop and CLR_OVF occur in the same cycle, the set wins.
- Count: a simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, HOLD, WAIT_RISE, WAIT_FALL.
  - IDLE: if !EMPTY && !BUSY, pop the head into OUT_DATA, set OUT_VLD=1, set cnt=0 and go to HOLD. Otherwise stay.
  - HOLD: cnt increments each cycle. When cnt == HOLD_CNT, clear OUT_VLD and OUT_DATA, set cnt=0 and go to WAIT_RISE.
  - WAIT_RISE: on BUSY==1, go to WAIT_FALL. If BUSY is still 0 when cnt == HOLD_CNT, assume the transfer was missed or already completed and go to IDLE. Otherwise cnt increments.
  - WAIT_FALL: on BUSY==0, go to IDLE.
- HOLD_CNT is sampled every cycle. Changing it while in HOLD is not supported.
- If cnt would pass HOLD_CNT because HOLD_CNT changed, cnt wraps and the state is left on the next match (no lockup requirement beyond that).

## Timing
- IN_VLD sampled at edge k into an empty FIFO, in IDLE, with BUSY=0: EMPTY goes low after edge k, and OUT_VLD goes high after edge k+1 (2-cycle latency).
- OUT_VLD is high for exactly HOLD_CNT+1 consecutive cycles. OUT_DATA is stable throughout.
- Minimum gap between two OUT_VLD pulses:
  - WAIT_RISE timeout path: HOLD_CNT+2 cycles.
  - BUSY path: 1 cycle after BUSY falls, plus the IDLE pop cycle.
- FULL and EMPTY are registered and change the cycle after the push or pop edge.

## Structure
- Package tx_stretch_pkg holds:
  - the state enum (IDLE, HOLD, WAIT_RISE, WAIT_FALL)
  - the localparam PTR_WIDTH = $clog2(DEPTH)
  - the default CNT_WIDTH.
- One sub-module, sync_fifo (DATA_WIDTH, DEPTH): storage, pointers, count, FULL/EMPTY.
- FSM, counter and OVF logic live in tx_stretch_buffer.

## Test plan
- Single byte: HOLD_CNT=15, IN_DATA=0xA5 pulse, BUSY pulses high for 40 cycles starting 20 cycles after OUT_VLD rises → OUT_VLD high exactly 16 cycles with 0xA5, OUT_DATA=0 afterwards, next pop only after BUSY falls.
- Burst: 4 back-to-back writes 0x11,0x22,0x33,0x44 with DEPTH=4 → FULL=1 after the 4th, bytes emitted in order, EMPTY=1 after the last pop, OVF=0.
- Overflow: 5 writes with BUSY held 1 → 5th byte dropped, OVF=1 and stays 1 until a CLR_OVF pulse; output order is 0x11..0x44.
- Timeout: HOLD_CNT=3, BUSY tied 0 → OUT_VLD 4 cycles high, low 5 cycles, then the next byte.
- Reset mid-HOLD: RST=0 for one cycle on the 3rd valid cycle → OUT_VLD=0, EMPTY=1, state IDLE the cycle after; a subsequent write behaves as in the first scenario.
- Wrap-around and HOLD_CNT=0: 10 bytes through DEPTH=4 with random BUSY timing → no loss or duplication; OUT_VLD is a 1-cycle pulse when HOLD_CNT=0.
